// File: rtl/srio_type9_stream_sched.sv
// srio_type9_stream_sched: round-robin packet-boundary scheduler feeding one SRIO Type 9 packer from NUM_CH AXI-Stream sources
module srio_type9_stream_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESETN,
  input  logic [NUM_CH-1:0]    ch_tvalid,
  output logic [NUM_CH-1:0]    ch_tready,
  input  logic [64*NUM_CH-1:0] ch_tdata,
  input  logic [NUM_CH-1:0]    ch_tlast,
  input  logic [16*NUM_CH-1:0] ch_stream_id,
  input  logic [16*NUM_CH-1:0] ch_length,
  input  logic [8*NUM_CH-1:0]  ch_cos,
  input  logic [32*NUM_CH-1:0] ch_srcdest,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_abort,
  output logic                 pk_tvalid,
  output logic [63:0]          pk_tdata,
  output logic                 pk_tlast,
  input  logic                 pk_tready,
  input  logic                 pk_m_tvalid,
  input  logic                 pk_m_tready,
  input  logic                 pk_m_tlast,
  output logic [31:0]          pk_cmd,
  output logic [15:0]          pk_stream_id,
  output logic [15:0]          pk_length,
  output logic [7:0]           pk_cos,
  output logic [31:0]          pk_srcdest,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [CNT_W-1:0]     pkt_count
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {IDLE, GRANT, PASS, DRAIN} state_t;
  state_t state, state_d;
  logic [IW-1:0] gnt, rr, sel, gnt_nxt;
  logic [CW-1:0] c;
  logic [12:0] cnt, w;
  logic [NUM_CH-1:0] elig;
  logic found, pass, in_fire, m_fire, done_ev, start_q, reset_q;
  logic [63:0] dat [NUM_CH];
  logic [15:0] sid [NUM_CH];
  logic [15:0] len [NUM_CH];
  logic [7:0]  cos [NUM_CH];
  logic [31:0] sd  [NUM_CH];
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    assign dat[i]  = ch_tdata[64*i +: 64];
    assign sid[i]  = ch_stream_id[16*i +: 16];
    assign len[i]  = ch_length[16*i +: 16];
    assign cos[i]  = ch_cos[8*i +: 8];
    assign sd[i]   = ch_srcdest[32*i +: 32];
    assign elig[i] = ch_enable[i] & ch_tvalid[i] & (len[i] != 16'd0) & ctrl_enable;
  end
  // Search from the rr pointer, wrapping modulo NUM_CH; the first eligible channel wins
  always_comb begin
    found = 1'b0;
    sel = rr;
    c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = CW'(rr) + CW'(k);
      c = (c >= CW'(NUM_CH)) ? c - CW'(NUM_CH) : c;
      if (!found && elig[c[IW-1:0]]) begin
        found = 1'b1;
        sel = c[IW-1:0];
      end
    end
  end
  assign pass      = state == PASS;
  assign pk_tvalid = pass & ch_tvalid[gnt];
  assign pk_tdata  = pass ? dat[gnt] : 64'd0;
  assign pk_tlast  = pass & (ch_tlast[gnt] | (cnt + 13'd1 == w));
  assign ch_tready = pass ? (NUM_CH'(pk_tready) << gnt) : '0;
  assign in_fire   = pk_tvalid & pk_tready;
  assign m_fire    = pk_m_tvalid & pk_m_tready & pk_m_tlast;
  // A packer tlast only closes our packet once we are draining; earlier ones belong to the previous packet
  assign done_ev   = (state == DRAIN) & m_fire & ~ctrl_abort;
  assign gnt_nxt   = (gnt == IW'(NUM_CH - 1)) ? '0 : gnt + IW'(1);
  assign busy      = state != IDLE;
  assign grant_id  = 3'(gnt);
  assign pk_cmd    = {30'd0, reset_q, start_q};
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = found ? GRANT : IDLE;
      GRANT:   state_d = PASS;
      PASS:    state_d = (in_fire & pk_tlast) ? DRAIN : PASS;
      DRAIN:   state_d = m_fire ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (ctrl_abort) state_d = IDLE;
  end
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN)
    if (!AXIS_ARESETN) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      gnt <= '0;
      rr <= '0;
      cnt <= '0;
      w <= '0;
      pk_stream_id <= '0;
      pk_length <= '0;
      pk_cos <= '0;
      pk_srcdest <= '0;
      pkt_done <= 1'b0;
      pkt_count <= '0;
      start_q <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= ctrl_enable;
      reset_q <= ctrl_abort;
      pkt_done <= done_ev;
      if (done_ev) pkt_count <= pkt_count + CNT_W'(1);
      if (state == IDLE && state_d == GRANT) begin
        gnt <= sel;
        pk_stream_id <= sid[sel];
        pk_length <= len[sel];
        pk_cos <= cos[sel];
        pk_srcdest <= sd[sel];
        w <= len[sel][15:3] + {12'd0, |len[sel][2:0]};
      end
      if (state == GRANT) cnt <= '0;
      else if (pass & in_fire) cnt <= cnt + 13'd1;
      if (state != IDLE && state_d == IDLE) rr <= gnt_nxt;
    end
  end
endmodule

// File: tb/tb_srio_type9_stream_sched.sv
// tb_srio_type9_stream_sched: random source streams checked against a packet-level round-robin model
module tb_srio_type9_stream_sched;
  localparam int N = 4;
  logic AXIS_ACLK = 1'b0;
  logic AXIS_ARESETN = 1'b0;
  logic [N-1:0] ch_tvalid, ch_tready, ch_tlast, ch_enable;
  logic [64*N-1:0] ch_tdata;
  logic [16*N-1:0] ch_stream_id, ch_length;
  logic [8*N-1:0] ch_cos;
  logic [32*N-1:0] ch_srcdest;
  logic ctrl_enable, ctrl_abort, pk_tvalid, pk_tlast, pk_tready;
  logic pk_m_tvalid, pk_m_tready, pk_m_tlast, busy, pkt_done;
  logic [63:0] pk_tdata;
  logic [31:0] pk_cmd, pk_srcdest, pkt_count;
  logic [15:0] pk_stream_id, pk_length;
  logic [7:0] pk_cos;
  logic [2:0] grant_id;
  srio_type9_stream_sched #(.NUM_CH(N), .CNT_W(32)) dut (
    .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN),
    .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .ch_tdata(ch_tdata), .ch_tlast(ch_tlast),
    .ch_stream_id(ch_stream_id), .ch_length(ch_length), .ch_cos(ch_cos), .ch_srcdest(ch_srcdest),
    .ch_enable(ch_enable), .ctrl_enable(ctrl_enable), .ctrl_abort(ctrl_abort),
    .pk_tvalid(pk_tvalid), .pk_tdata(pk_tdata), .pk_tlast(pk_tlast), .pk_tready(pk_tready),
    .pk_m_tvalid(pk_m_tvalid), .pk_m_tready(pk_m_tready), .pk_m_tlast(pk_m_tlast),
    .pk_cmd(pk_cmd), .pk_stream_id(pk_stream_id), .pk_length(pk_length), .pk_cos(pk_cos),
    .pk_srcdest(pk_srcdest), .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done),
    .pkt_count(pkt_count)
  );
  always #5 AXIS_ACLK = ~AXIS_ACLK;
  logic [63:0] sdat [N][$];
  bit slast [N][$];
  logic [15:0] cfg_len [N];
  logic [15:0] cfg_sid [N];
  logic [7:0]  cfg_cos [N];
  logic [31:0] cfg_sd  [N];
  bit cfg_en [N];
  logic [63:0] exp_data [$];
  bit exp_last [$];
  int exp_ch [$];
  int rr_m, total_pkts, done_seen, m_wait, rdy_mode, n_chk, n_pass;
  int hs [N];
  bit pending, mon_on, abort_req, hold_rdy, tog;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      sdat[i].delete();
      slast[i].delete();
      cfg_en[i] = 1'b0;
      cfg_len[i] = '0;
      cfg_sid[i] = '0;
      cfg_cos[i] = '0;
      cfg_sd[i] = '0;
    end
  endtask
  // tlast every pkt_beats beats (0 = only on the final beat)
  task automatic load(input int c, input logic [15:0] len, input int beats, input int pkt_beats);
    for (int b = 1; b <= beats; b++) begin
      sdat[c].push_back({$urandom, $urandom});
      slast[c].push_back(b == beats || (pkt_beats > 0 && b % pkt_beats == 0));
    end
    cfg_en[c] = 1'b1;
    cfg_len[c] = len;
    cfg_sid[c] = 16'($urandom);
    cfg_cos[c] = 8'($urandom);
    cfg_sd[c] = $urandom;
  endtask
  task automatic do_reset();
    AXIS_ARESETN = 1'b0;
    ctrl_enable = 1'b0;
    ctrl_abort = 1'b0;
    pk_tready = 1'b0;
    pk_m_tvalid = 1'b0;
    pk_m_tready = 1'b0;
    pk_m_tlast = 1'b0;
    ch_tvalid = '0;
    ch_tlast = '0;
    ch_enable = '0;
    ch_tdata = '0;
    ch_stream_id = '0;
    ch_length = '0;
    ch_cos = '0;
    ch_srcdest = '0;
    clear_src();
    exp_data.delete();
    exp_last.delete();
    exp_ch.delete();
    rr_m = 0;
    total_pkts = 0;
    done_seen = 0;
    pending = 1'b0;
    abort_req = 1'b0;
    hold_rdy = 1'b0;
    for (int i = 0; i < N; i++) hs[i] = 0;
    repeat (2) @(negedge AXIS_ACLK);
    AXIS_ARESETN = 1'b1;
  endtask
  task automatic cycle();
    logic [N-1:0] exp_oh;
    int c;
    @(negedge AXIS_ACLK);
    for (int i = 0; i < N; i++) begin
      ch_tvalid[i] = sdat[i].size() > 0;
      ch_tdata[64*i +: 64] = ch_tvalid[i] ? sdat[i][0] : 64'd0;
      ch_tlast[i] = ch_tvalid[i] && slast[i][0];
      ch_enable[i] = cfg_en[i];
      ch_length[16*i +: 16] = cfg_len[i];
      ch_stream_id[16*i +: 16] = cfg_sid[i];
      ch_cos[8*i +: 8] = cfg_cos[i];
      ch_srcdest[32*i +: 32] = cfg_sd[i];
    end
    tog = ~tog;
    pk_tready = hold_rdy ? 1'b0 : rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? tog : 1'($urandom_range(0, 1));
    ctrl_abort = abort_req;
    abort_req = 1'b0;
    hold_rdy = 1'b0;
    // Packer master: one closing tlast per packet after a short delay, random noise otherwise
    if (pending) begin
      pk_m_tvalid = m_wait == 0;
      pk_m_tready = m_wait == 0;
      pk_m_tlast = m_wait == 0;
    end else begin
      pk_m_tvalid = 1'($urandom_range(0, 1));
      pk_m_tready = 1'($urandom_range(0, 1));
      pk_m_tlast = 1'($urandom_range(0, 1));
    end
    #4;
    done_seen += int'(pkt_done);
    if (mon_on) begin
      exp_oh = exp_ch.size() > 0 ? (N'(1) << exp_ch[0]) : '0;
      if (ch_tready != '0) check("tready_sel", 64'(ch_tready & ~exp_oh), 64'd0);
      if (pk_tvalid && pk_tready) begin
        if (exp_data.size() == 0) check("extra_beat", 64'd1, 64'd0);
        else begin
          c = exp_ch.pop_front();
          check("data", pk_tdata, exp_data.pop_front());
          check("last", 64'(pk_tlast), 64'(exp_last.pop_front()));
          check("grant", 64'(grant_id), 64'(c));
          check("length", 64'(pk_length), 64'(cfg_len[c]));
          check("stream_id", 64'(pk_stream_id), 64'(cfg_sid[c]));
          check("cos", 64'(pk_cos), 64'(cfg_cos[c]));
          check("srcdest", 64'(pk_srcdest), 64'(cfg_sd[c]));
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (ch_tvalid[i] && ch_tready[i]) begin
        void'(sdat[i].pop_front());
        void'(slast[i].pop_front());
        hs[i]++;
      end
    if (pending) begin
      if (m_wait == 0) pending = 1'b0;
      else m_wait--;
    end else if (pk_tvalid && pk_tready && pk_tlast) begin
      pending = 1'b1;
      m_wait = $urandom_range(0, 3);
    end
  endtask
  // Model: each grant takes beats from the first eligible channel (from rr) up to its tlast or ceil(len/8) beats
  task automatic run_round();
    logic [63:0] md [N][$];
    bit ml [N][$];
    int orig [N];
    bit ok [N];
    int c, w, k, t;
    bit l;
    for (int i = 0; i < N; i++) begin
      md[i] = sdat[i];
      ml[i] = slast[i];
      orig[i] = sdat[i].size();
      ok[i] = cfg_en[i] && cfg_len[i] != 16'd0;
    end
    forever begin
      c = -1;
      for (int j = 0; j < N; j++)
        if (c < 0 && ok[(rr_m + j) % N] && md[(rr_m + j) % N].size() > 0) c = (rr_m + j) % N;
      if (c < 0) break;
      w = (int'(cfg_len[c]) + 7) / 8;
      k = 0;
      do begin
        k++;
        l = ml[c].pop_front() || k == w;
        exp_data.push_back(md[c].pop_front());
        exp_last.push_back(l);
        exp_ch.push_back(c);
      end while (!l);
      rr_m = (c + 1) % N;
      total_pkts++;
    end
    mon_on = 1'b1;
    ctrl_enable = 1'b0;
    repeat (3) cycle();
    check("idle_when_disabled", 64'(busy), 64'd0);
    ctrl_enable = 1'b1;
    cycle();
    cycle();
    check("cmd_start", 64'(pk_cmd), 64'd1);
    t = 0;
    while ((exp_data.size() > 0 || pending) && t < 4000) begin
      cycle();
      t++;
    end
    repeat (3) cycle();
    check("beats_left", 64'(exp_data.size()), 64'd0);
    check("pkt_count", 64'(pkt_count), 64'(total_pkts));
    check("pkt_done_pulses", 64'(done_seen), 64'(total_pkts));
    for (int i = 0; i < N; i++)
      if (orig[i] > 0) check("src_remaining", 64'(sdat[i].size()), ok[i] ? 64'd0 : 64'(orig[i]));
    clear_src();
  endtask
  initial begin
    n_chk = 0;
    n_pass = 0;
    tog = 1'b0;
    rdy_mode = 0;
    mon_on = 1'b0;
    do_reset();
    AXIS_ARESETN = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pk_tvalid", 64'(pk_tvalid), 64'd0);
    check("rst_pk_cmd", 64'(pk_cmd), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_pk_length", 64'(pk_length), 64'd0);
    check("rst_pkt_done", 64'(pkt_done), 64'd0);
    check("rst_ch_tready", 64'(ch_tready), 64'd0);
    @(negedge AXIS_ACLK);
    AXIS_ARESETN = 1'b1;
    load(0, 16'd24, 3, 0);
    run_round();
    for (int i = 0; i < N; i++) load(i, 16'd16, 4, 2);
    run_round();
    load(1, 16'd20, 6, 0);
    run_round();
    rdy_mode = 1;
    load(2, 16'd64, 8, 0);
    run_round();
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 4) != 0) begin
          load(i, $urandom_range(0, 9) == 0 ? 16'd0 : 16'($urandom_range(1, 96)),
               $urandom_range(1, 14), $urandom_range(0, 6));
          if ($urandom_range(0, 5) == 0) cfg_en[i] = 1'b0;
        end
      run_round();
    end
    // Abort mid-packet on channel 2; channel 3 must get the next grant
    do_reset();
    mon_on = 1'b0;
    rdy_mode = 0;
    load(2, 16'd64, 8, 0);
    load(3, 16'd16, 2, 0);
    ctrl_enable = 1'b1;
    for (int t = 0; t < 50 && hs[2] < 2; t++) cycle();
    check("abort_setup_beats", 64'(hs[2]), 64'd2);
    abort_req = 1'b1;
    hold_rdy = 1'b1;
    cycle();
    cycle();
    check("abort_cmd", 64'(pk_cmd), 64'h3);
    check("abort_idle", 64'(busy), 64'd0);
    cycle();
    check("abort_cmd_clear", 64'(pk_cmd), 64'h1);
    check("abort_regrant_busy", 64'(busy), 64'd1);
    check("abort_next_grant", 64'(grant_id), 64'd3);
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_pkt_count", 64'(pkt_count), 64'd0);
    check("abort_ch2_beats", 64'(hs[2]), 64'd2);
    // Asynchronous reset in the middle of a packet
    do_reset();
    load(1, 16'd160, 20, 0);
    ctrl_enable = 1'b1;
    for (int t = 0; t < 20 && !(busy && pk_tvalid); t++) cycle();
    cycle();
    check("pre_reset_pass", 64'(busy && pk_tvalid), 64'd1);
    @(negedge AXIS_ACLK);
    #2;
    AXIS_ARESETN = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_pk_tvalid", 64'(pk_tvalid), 64'd0);
    check("arst_pk_tdata", pk_tdata, 64'd0);
    check("arst_ch_tready", 64'(ch_tready), 64'd0);
    check("arst_grant_id", 64'(grant_id), 64'd0);
    check("arst_pk_length", 64'(pk_length), 64'd0);
    check("arst_pk_stream_id", 64'(pk_stream_id), 64'd0);
    check("arst_pk_cmd", 64'(pk_cmd), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/srio_type9_stream_sched.md
Name: srio_type9_stream_sched

Overview:
- Round-robin scheduler that shares one SRIO Type 9 packer between NUM_CH independent 64-bit AXI-Stream sources.
- Arbitrates only at packet boundaries and muxes the granted channel's payload into the packer's slave stream.
- Drives the packer's per-packet header fields (stream ID, length, COS, srcdest) and holds them stable until the packer has emitted the packet's final beat.
- Generates the packer's cmd word (start/reset).

Parameters:
- NUM_CH, 4: number of source channels (2..8).
- CNT_W, 32: width of the packet-done counter.

Ports:
- AXIS_ACLK  in  1  clock
- AXIS_ARESETN  in  1  asynchronous active-low reset
- ch_tvalid  in  NUM_CH  per-channel source valid
- ch_tready  out  NUM_CH  per-channel source ready
- ch_tdata  in  64*NUM_CH  per-channel payload; channel i at [64i+63:64i]
- ch_tlast  in  NUM_CH  per-channel end of packet
- ch_stream_id  in  16*NUM_CH  per-channel stream ID
- ch_length  in  16*NUM_CH  per-channel length in bytes
- ch_cos  in  8*NUM_CH  per-channel class of service
- ch_srcdest  in  32*NUM_CH  per-channel SRIO src/dest
- ch_enable  in  NUM_CH  channel eligible for arbitration
- ctrl_enable  in  1  scheduler run
- ctrl_abort  in  1  single-cycle abort pulse
- pk_tvalid / pk_tdata[63:0] / pk_tlast  out  packer slave stream
- pk_tready  in  1  packer slave ready
- pk_m_tvalid / pk_m_tready / pk_m_tlast  in  1 each  monitor taps on the packer master stream
- pk_cmd  out  32  packer command; bit0 = start, bit1 = reset, others 0
- pk_stream_id  out  16, pk_length  out  16, pk_cos  out  8, pk_srcdest  out  32  header fields
- grant_id  out  3  current or last granted channel
- busy  out  1  packet in flight
- pkt_done  out  1  single-cycle pulse per completed packet
- pkt_count  out  CNT_W  completed packets, wraps

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; beat counter 0.
- States:
  - IDLE: wait for a request.
  - GRANT: latch the granted channel's config.
  - PASS: stream payload into the packer.
  - DRAIN: wait for the packer to finish emitting the packet.
- Eligible request, channel i: ch_enable[i] & ch_tvalid[i] & (ch_length[i] != 0) & ctrl_enable.
- IDLE -> GRANT when any channel is eligible. Search starts at the rr pointer and wraps modulo NUM_CH; the first eligible channel wins.
- GRANT (exactly 1 cycle):
  - Register grant_id and the channel's stream_id, length, cos and srcdest onto the pk_* fields.
  - Beat target W = ceil(length/8) = length[15:3] + (length[2:0] != 0); 13-bit counter.
  - Counter cleared.
  - Go to PASS.
- PASS:
  - pk_tvalid = ch_tvalid[g]; pk_tdata = ch_tdata[g]; ch_tready[g] = pk_tready; all other ch_tready = 0. This path is combinational (zero latency).
  - pk_tlast = ch_tlast[g] | (cnt+1 == W).
  - Each pk_tvalid & pk_tready increments cnt.
  - A transfer with pk_tlast = 1 moves to DRAIN. Source beats after a forced last belong to that channel's next packet.
- DRAIN:
  - pk_tvalid = 0; all ch_tready = 0.
  - On pk_m_tvalid & pk_m_tready & pk_m_tlast: pulse pkt_done, increment pkt_count, set rr pointer to (g+1) mod NUM_CH, go to IDLE.
  - Header fields stay stable from GRANT through the end of DRAIN.
- If the packer output last occurs in the same cycle as the PASS last input beat, remain correct: that packer tlast belongs to the previous packet, so only a packer tlast seen while in DRAIN counts.
- busy = 1 in GRANT, PASS and DRAIN.
- pk_cmd[0] = ctrl_enable, registered.
- pk_cmd[1]:
  - High for exactly one cycle, the cycle after ctrl_abort.
  - State -> IDLE; no pkt_done; rr pointer still advances to g+1.
  - The partial packet is discarded; the source must resend.
  - Abort while IDLE only produces the cmd[1] pulse.
- ctrl_enable deasserted mid-packet: the current packet completes normally; no new grant is made.
- ch_enable[g] dropping mid-packet is ignored until the packet ends.
- Config inputs changing after GRANT have no effect on the current packet.
- Counters wrap silently.

Test Plan:
- Single channel 0, length 24, 3 beats, tlast on beat 3, sink always ready. Required: one GRANT, pk_length = 24, 3 payload beats, one pkt_done after the packer output tlast, pkt_count = 1.
- Channels 0–3 all requesting continuously with length 16. Required: grants in order 0,1,2,3,0 with no channel repeated before the others are served.
- Channel 1, length 20 (W = 3), source never asserts tlast. Required: pk_tlast forced on beat 3; beat 4 held with ch_tready[1] = 0 until the next grant.
- Channel 2, length 64, pk_tready toggled every cycle. Required: exactly 8 beats, data in order; pk_stream_id held constant until DRAIN exits.
- ctrl_abort on beat 2 of 8. Required: pk_cmd = 0x3 for one cycle, return to IDLE, no pkt_done, next grant goes to channel g+1.
- Channel with length 0 or ch_enable = 0 while requesting. Required: never granted; AXIS_ARESETN low mid-PASS returns all outputs to 0 asynchronously.
